rgbled_ctrl: RTL



---
 rtl/rgbled_pkg.sv | 26 ++
 rtl/rgbled_timer.sv | 34 +++
 rtl/rgbled_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rgbled_pkg.sv
// Shared types and helpers for the WS281x frame sequencer.
package rgbled_pkg;

  // One LED colour word in the order the WS281x shifts it out.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    DRAIN,
    LATCH
  } rgbled_state_e;

  localparam rgb_t RGB_OFF = '0;

  // Counter/index width for n states, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgbled_timer.sv
// Up-counter that wraps at Cycles-1 and flags the wrap cycle on o_tc.
// Cycles must be >= 1.
module rgbled_timer
  import rgbled_pkg::*;
#(
  parameter int unsigned Cycles = 2
) (
  input  logic main_clk_buf,
  input  logic rst_sys_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CntW = cnt_width(Cycles);
  localparam logic [CntW-1:0] TermCnt = CntW'(Cycles - 1);

  logic [CntW-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == TermCnt);

  // Count enabled cycles; clear has priority, terminal count wraps to zero.
  always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_sys_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rgbled_ctrl.sv
// WS281x frame sequencer: double-buffered colour table streamed to ws281x_drv,
// followed by the latch gap. Frames start on update_i or periodic refresh.
module rgbled_ctrl
  import rgbled_pkg::*;
#(
  parameter int unsigned NumLeds       = 2,
  parameter int unsigned LatchCycles   = 2000,
  parameter int unsigned RefreshCycles = 250000,
  localparam int unsigned IdxW         = cnt_width(NumLeds)
) (
  input  logic            main_clk_buf,
  input  logic            rst_sys_n,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [23:0]     wr_data_i,
  input  logic            update_i,
  input  logic            off_i,
  output logic            busy_o,
  output logic            frame_done_o,
  output logic            drv_go_o,
  output logic [23:0]     drv_data_o,
  output logic            drv_data_valid_o,
  output logic            drv_data_last_o,
  input  logic            drv_data_ack_i,
  input  logic            drv_idle_i
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLeds - 1);

  rgbled_state_e   r_state, w_state_next;
  rgb_t            r_shadow [NumLeds];
  rgb_t            r_active [NumLeds];
  logic [IdxW-1:0] r_idx, w_idx_next;
  logic            r_pending;
  logic            r_go, r_valid, r_last, r_frame_done;
  rgb_t            r_data;
  logic            w_go_next, w_valid_next, w_last_next, w_frame_done_next;
  rgb_t            w_data_next;
  logic            w_refresh_tc, w_latch_tc, w_req;

  if (RefreshCycles != 0) begin : g_refresh
    rgbled_timer #(.Cycles(RefreshCycles)) u_refresh_timer (
      .main_clk_buf (main_clk_buf),
      .rst_sys_n    (rst_sys_n),
      .i_clr        (1'b0),
      .i_en         (1'b1),
      .o_tc         (w_refresh_tc)
    );
  end else begin : g_no_refresh
    assign w_refresh_tc = 1'b0;
  end

  // Latch counter is held cleared in DRAIN so LATCH lasts exactly LatchCycles cycles.
  rgbled_timer #(.Cycles(LatchCycles)) u_latch_timer (
    .main_clk_buf (main_clk_buf),
    .rst_sys_n    (rst_sys_n),
    .i_clr        (r_state == DRAIN),
    .i_en         (r_state == LATCH),
    .o_tc         (w_latch_tc)
  );

  assign w_req = update_i || w_refresh_tc;

  // Software writes land in the shadow table only, in any state.
  always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
    // NOTE: the tables are small flop arrays and must power up dark, so they are reset like any other state.
    if (!rst_sys_n) begin
      for (int i = 0; i < int'(NumLeds); i++) r_shadow[i] <= RGB_OFF;
    end else if (wr_en_i && (32'(wr_idx_i) < NumLeds)) begin
      r_shadow[wr_idx_i] <= wr_data_i;
    end
  end

  // Snapshot the whole shadow table into the active table during LOAD.
  always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      for (int i = 0; i < int'(NumLeds); i++) r_active[i] <= RGB_OFF;
    end else if (r_state == LOAD) begin
      r_active <= r_shadow;
    end
  end

  // Frame request flag: starts at 1 for the post-reset blank frame; a new request beats the LOAD clear.
  always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_pending <= 1'b1;
    end else if (w_req) begin
      r_pending <= 1'b1;
    end else if (r_state == LOAD) begin
      r_pending <= 1'b0;
    end
  end

  // Next state and next registered driver outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_go_next         = 1'b0;
    w_valid_next      = 1'b0;
    w_last_next       = 1'b0;
    w_data_next       = RGB_OFF;
    w_frame_done_next = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pending || w_req) w_state_next = LOAD;
      end
      LOAD: begin
        // Active is being loaded from shadow this edge, so word 0 comes straight from shadow.
        w_state_next = SEND;
        w_idx_next   = '0;
        w_go_next    = 1'b1;
        w_valid_next = 1'b1;
        w_last_next  = (LastIdx == '0);
        w_data_next  = off_i ? RGB_OFF : r_shadow[0];
      end
      SEND: begin
        w_go_next    = 1'b1;
        w_valid_next = 1'b1;
        w_last_next  = r_last;
        w_data_next  = r_data;
        if (drv_data_ack_i) begin
          if (r_last) begin
            w_state_next = DRAIN;
            w_go_next    = 1'b0;
            w_valid_next = 1'b0;
            w_last_next  = 1'b0;
            w_data_next  = RGB_OFF;
          end else begin
            w_idx_next  = r_idx + 1'b1;
            w_last_next = (w_idx_next == LastIdx);
            w_data_next = off_i ? RGB_OFF : r_active[w_idx_next];
          end
        end
      end
      DRAIN: begin
        if (drv_idle_i) w_state_next = LATCH;
      end
      LATCH: begin
        if (w_latch_tc) begin
          w_state_next      = IDLE;
          w_frame_done_next = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, word index and registered driver-facing outputs.
  always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_go         <= 1'b0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_data       <= RGB_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_go         <= w_go_next;
      r_valid      <= w_valid_next;
      r_last       <= w_last_next;
      r_data       <= w_data_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign busy_o           = (r_state != IDLE);
  assign frame_done_o     = r_frame_done;
  assign drv_go_o         = r_go;
  assign drv_data_o       = r_data;
  assign drv_data_valid_o = r_valid;
  assign drv_data_last_o  = r_last;

endmodule
